line_in_receiver: RTL and testbench

//  I2S master receiver for the line-in Pmod (CS5343-class ADC); the capture-side counterpart of speaker_control.

---
 rtl/audio_pkg.sv | 34 +++
 rtl/i2s_clock_gen.sv | 33 +++
 rtl/line_in_receiver.sv | 123 ++++++++++++
 tb/tb_line_in_receiver.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared I2S timing constants, sample types and helpers used by the
// line-in receiver and the speaker path.
//   Timebase: one 10-bit free-running counter at the system clock.
//     mclk = cnt[MCLK_BIT], sck = cnt[SCK_BIT], lrck = cnt[LRCK_BIT].
//   Data bits are sampled on the first clk of sck high, in slots 1..16.
package audio_pkg;

  localparam int CNT_W          = 10;
  localparam int MCLK_BIT       = 1;
  localparam int SCK_BIT        = 3;
  localparam int LRCK_BIT       = 9;
  localparam logic [3:0] CAPTURE_PHASE = 4'd8;

  localparam int FIRST_BIT_SLOT = 1;
  localparam int LAST_BIT_SLOT  = 16;
  localparam int SAMPLE_W       = 16;
  localparam int PEAK_W         = 15;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } sample_pair_t;

  // Magnitude of a two's complement sample; -32768 saturates to 32767 so the
  // result always fits in PEAK_W bits.
  function automatic logic [PEAK_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] neg;
    neg = ~s + 1'b1;
    if (!s[SAMPLE_W-1])      return s[PEAK_W-1:0];
    else if (neg[SAMPLE_W-1]) return '1;  // only the most negative code negates to itself
    else                     return neg[PEAK_W-1:0];
  endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// i2s_clock_gen: free-running I2S timebase.
//   clk_i   system clock
//   rst_i   synchronous active-high reset; counter restarts at 0
//   cnt_o   10-bit position within the 1024-clk frame
//   mclk_o  clk/4, sck_o clk/16, lrck_o clk/1024 (0 = left half)
// The serial clocks are plain counter bits, so they are glitch-free and
// their phase relation to cnt_o is fixed.
module i2s_clock_gen
  import audio_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             mclk_o,
  output logic             sck_o,
  output logic             lrck_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = cnt_q + 1'b1;  // natural wrap 1023 -> 0

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign mclk_o = cnt_q[MCLK_BIT];
  assign sck_o  = cnt_q[SCK_BIT];
  assign lrck_o = cnt_q[LRCK_BIT];

endmodule

// File: rtl/line_in_receiver.sv
// line_in_receiver: I2S master receiver for the line-in ADC.
//   clk, rst        100 MHz clock, synchronous active-high reset
//   audio_mclk/sck/lrck  generated serial clocks
//   audio_sdout     serial data from the ADC
//   sample_left/right    last complete L/R pair (two's complement)
//   sample_valid    one-clk strobe when the pair updates (cnt == 777)
//   level           3-bit peak meter, refreshed with each strobe
module line_in_receiver
  import audio_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int PEAK_DECAY = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              audio_mclk,
  output logic              audio_lrck,
  output logic              audio_sck,
  input  logic              audio_sdout,
  output logic [DATA_W-1:0] sample_left,
  output logic [DATA_W-1:0] sample_right,
  output logic              sample_valid,
  output logic [2:0]        level
);

  localparam logic [4:0]        FIRST_SLOT = 5'(FIRST_BIT_SLOT);
  localparam logic [4:0]        LAST_SLOT  = 5'(LAST_BIT_SLOT);
  localparam logic [PEAK_W-1:0] DECAY      = PEAK_W'(PEAK_DECAY);

  logic [CNT_W-1:0] cnt;

  i2s_clock_gen u_clk_gen (
    .clk_i  (clk),
    .rst_i  (rst),
    .cnt_o  (cnt),
    .mclk_o (audio_mclk),
    .sck_o  (audio_sck),
    .lrck_o (audio_lrck)
  );

  // ---- frame position decode ----
  logic [3:0] phase;
  logic [4:0] slot;
  logic       chan;
  logic       cap_en, last_bit, pair_fire;

  assign phase = cnt[SCK_BIT:0];
  assign slot  = cnt[LRCK_BIT-1:SCK_BIT+1];
  assign chan  = cnt[LRCK_BIT];

  // Slot 0 is the I2S one-bit delay; slots past 16 carry nothing we keep.
  assign cap_en    = (phase == CAPTURE_PHASE) && (slot >= FIRST_SLOT) && (slot <= LAST_SLOT);
  assign last_bit  = cap_en && (slot == LAST_SLOT);
  assign pair_fire = last_bit && chan;

  // ---- state ----
  logic                sd_q;
  logic [SAMPLE_W-1:0] shift_q, shift_d, shift_nxt;
  logic [SAMPLE_W-1:0] shadow_q, shadow_d;
  sample_pair_t        pair_q, pair_d;
  logic                valid_q, valid_d;
  logic [PEAK_W-1:0]   peak_q, peak_d;
  logic [2:0]          level_q, level_d;
  logic [PEAK_W-1:0]   mag_l, mag_r, mag;

  assign shift_nxt = {shift_q[SAMPLE_W-2:0], sd_q};

  always_comb begin
    shift_d  = shift_q;
    shadow_d = shadow_q;
    pair_d   = pair_q;
    valid_d  = 1'b0;
    if (cap_en) shift_d = shift_nxt;
    // Left word is parked until the right word completes so both publish together.
    if (last_bit && !chan) shadow_d = shift_nxt;
    if (pair_fire) begin
      pair_d.left  = shadow_q;
      pair_d.right = shift_nxt;
      valid_d      = 1'b1;
    end
  end

  // ---- peak meter: evaluated on the new pair, level lags peak by one pair ----
  always_comb begin
    mag_l   = abs_sat(pair_d.left);
    mag_r   = abs_sat(pair_d.right);
    mag     = (mag_l > mag_r) ? mag_l : mag_r;
    peak_d  = peak_q;
    level_d = level_q;
    if (pair_fire) begin
      level_d = peak_q[PEAK_W-1:PEAK_W-3];
      if (mag > peak_q)      peak_d = mag;
      else if (peak_q > DECAY) peak_d = peak_q - DECAY;
      else                   peak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sd_q     <= 1'b0;
      shift_q  <= '0;
      shadow_q <= '0;
      pair_q   <= '0;
      valid_q  <= 1'b0;
      peak_q   <= '0;
      level_q  <= '0;
    end else begin
      sd_q     <= audio_sdout;
      shift_q  <= shift_d;
      shadow_q <= shadow_d;
      pair_q   <= pair_d;
      valid_q  <= valid_d;
      peak_q   <= peak_d;
      level_q  <= level_d;
    end
  end

  assign sample_left  = pair_q.left;
  assign sample_right = pair_q.right;
  assign sample_valid = valid_q;
  assign level        = level_q;

endmodule

// File: tb/tb_line_in_receiver.sv
module tb_line_in_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        audio_sdout = 1'b0;
  logic        audio_mclk, audio_lrck, audio_sck;
  logic [15:0] sample_left, sample_right;
  logic        sample_valid;
  logic [2:0]  level;

  line_in_receiver #(.DATA_W(16), .PEAK_DECAY(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .audio_mclk   (audio_mclk),
    .audio_lrck   (audio_lrck),
    .audio_sck    (audio_sck),
    .audio_sdout  (audio_sdout),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .level        (level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Bench frame position: 0 on the first clk after reset release.
  logic [9:0] tcnt;
  always @(posedge clk) begin
    if (rst) tcnt <= '0;
    else     tcnt <= tcnt + 10'd1;
  end

  // ---- ADC model ----
  typedef struct { logic [15:0] l; logic [15:0] r; } pair_t;
  pair_t       expq[$];
  int          mode = 0;
  logic [15:0] cur_l = '0, cur_r = '0;

  function automatic logic [15:0] small_val(input int lo, input int hi);
    int m;
    m = $urandom_range(hi, lo);
    if ($urandom_range(1, 0) == 1) m = -m;
    return 16'(m);
  endfunction

  always @(negedge clk) begin
    int    s;
    logic [15:0] w;
    pair_t p;
    if (!rst && tcnt == 10'd1) begin
      case (mode)
        0: begin cur_l = 16'h1234; cur_r = 16'hABCD; end
        1: begin cur_l = 16'h8000; cur_r = 16'h0001; end
        2: begin cur_l = 16'h0000; cur_r = 16'h0000; end
        3: begin cur_l = 16'($urandom); cur_r = 16'($urandom); end
        4: begin
             if ($urandom_range(1, 0) == 1) begin cur_l = '0; cur_r = '0; end
             else begin cur_l = small_val(4090, 4130); cur_r = small_val(0, 4130); end
           end
        5: begin cur_l = 16'hFFFF; cur_r = 16'hFFFF; end
        default: begin cur_l = small_val(0, 40); cur_r = small_val(0, 40); end
      endcase
      p.l = cur_l; p.r = cur_r;
      expq.push_back(p);
    end
    s = int'(tcnt[8:4]);
    w = tcnt[9] ? cur_r : cur_l;
    if (s >= 1 && s <= 16) audio_sdout = w[16-s];
    else if (mode == 5)    audio_sdout = 1'b1;
    else if (mode == 2)    audio_sdout = 1'b0;
    else                   audio_sdout = 1'($urandom_range(1, 0));
  end

  // ---- reference model / scoreboard ----
  int          peak_m = 0;
  bit          have_last = 0;
  logic [15:0] last_l, last_r;

  function automatic int mag_of(input logic [15:0] v);
    int x;
    x = int'($signed(v));
    if (x < 0) x = -x;
    if (x > 32767) x = 32767;
    return x;
  endfunction

  always @(negedge clk) begin
    pair_t p;
    int    m;
    if (rst) begin
      expq.delete();
      peak_m    = 0;
      have_last = 0;
    end else begin
      if (tcnt == 10'd777) begin
        chk("valid_at_777", 32'(sample_valid), 32'd1);
        if (sample_valid) begin
          if (expq.size() == 0) chk("exp_queue_empty", 32'd1, 32'd0);
          else begin
            p = expq.pop_front();
            chk("sample_left", 32'(sample_left), 32'(p.l));
            chk("sample_right", 32'(sample_right), 32'(p.r));
            chk("level", 32'(level), 32'(peak_m / 4096));
            m = (mag_of(p.l) > mag_of(p.r)) ? mag_of(p.l) : mag_of(p.r);
            if (m > peak_m)       peak_m = m;
            else if (peak_m > 16) peak_m = peak_m - 16;
            else                  peak_m = 0;
            last_l = p.l; last_r = p.r; have_last = 1;
          end
        end
      end else if (sample_valid) begin
        chk("valid_stray_cnt", 32'(tcnt), 32'd777);
      end
      if (tcnt == 10'd100 && have_last) begin
        chk("hold_left", 32'(sample_left), 32'(last_l));
        chk("hold_right", 32'(sample_right), 32'(last_r));
      end
    end
  end

  // ---- serial clock period monitor ----
  int cyc = 0, rise_m = -1, rise_s = -1, rise_l = -1, tog_l = -1;
  logic pm = 0, ps = 0, pl = 0;

  always @(negedge clk) begin
    if (rst) begin
      cyc = 0; rise_m = -1; rise_s = -1; rise_l = -1; tog_l = -1;
      pm = audio_mclk; ps = audio_sck; pl = audio_lrck;
    end else begin
      cyc++;
      if (audio_mclk && !pm) begin
        if (rise_m >= 0) chk("mclk_period", 32'(cyc - rise_m), 32'd4);
        rise_m = cyc;
      end
      if (audio_sck && !ps) begin
        if (rise_s >= 0) chk("sck_period", 32'(cyc - rise_s), 32'd16);
        rise_s = cyc;
      end
      if (audio_lrck != pl) begin
        if (tog_l >= 0) chk("lrck_half", 32'(cyc - tog_l), 32'd512);
        tog_l = cyc;
        if (audio_lrck) begin
          if (rise_l >= 0) chk("lrck_period", 32'(cyc - rise_l), 32'd1024);
          rise_l = cyc;
        end
      end
      pm = audio_mclk; ps = audio_sck; pl = audio_lrck;
    end
  end

  // ---- sequence ----
  task automatic do_reset(input int n);
    @(posedge clk); #1 rst = 1'b1;
    repeat (n - 1) @(posedge clk);
    @(negedge clk);
    chk("rst_mclk", 32'(audio_mclk), 32'd0);
    chk("rst_sck", 32'(audio_sck), 32'd0);
    chk("rst_lrck", 32'(audio_lrck), 32'd0);
    chk("rst_left", 32'(sample_left), 32'd0);
    chk("rst_right", 32'(sample_right), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    repeat (n * 1024) @(posedge clk);
  endtask

  initial begin
    int k;
    do_reset(5);
    mode = 0; wait_frames(3);   // fixed 0x1234 / 0xABCD with garbage outside the data slots
    mode = 1; wait_frames(4);   // full-scale: peak saturates, level 7 one pair later
    mode = 2; wait_frames(3);   // silence: slow decay from the top
    mode = 5; wait_frames(2);   // constant high line
    mode = 3; wait_frames(6);   // random words
    mode = 4; wait_frames(10);  // peaks near the level 0/1 boundary
    mode = 3;
    k = 0;
    while (tcnt != 10'd600 && k < 2048) begin @(negedge clk); k++; end
    if (k >= 2048) chk("wait_cnt600_timeout", 32'd0, 32'd1);
    do_reset(3);                // abort mid right channel
    mode = 6; wait_frames(8);   // tiny peaks: decay must clamp at 0
    mode = 4; wait_frames(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
